// File: rtl/decode_stage.sv
// Registered RV32/RV64 integer decode stage with valid/ready handshake.
// Decodes one instruction per accepted beat, resolves branches against the
// supplied register values and presents the result one cycle later.
module decode_stage #(
  parameter int XLEN     = 64,
  parameter bit ENABLE_W = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rd1,
  input  logic [XLEN-1:0] in_rd2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_alu_b,
  output logic            out_word,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [2:0]      out_funct3,
  output logic            out_branch_taken,
  output logic [XLEN-1:0] out_branch_target,
  output logic            out_illegal
);

  // W forms only exist on a 64-bit datapath
  localparam bit W_ON = (XLEN == 64) && ENABLE_W;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOP  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1101;
  localparam logic [3:0] ALU_SRL  = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Shift-immediate upper bits: 6-bit shamt on RV64, 5-bit on RV32
  logic sh_lo_ok;
  logic sh_ra_ok;
  if (XLEN == 64) begin : g_sh64
    assign sh_lo_ok = (in_instr[31:26] == 6'b000000);
    assign sh_ra_ok = (in_instr[31:26] == 6'b010000);
  end else begin : g_sh32
    assign sh_lo_ok = (funct7 == 7'b0000000);
    assign sh_ra_ok = (funct7 == 7'b0100000);
  end

  logic br_eq, br_lt, br_ltu;
  assign br_eq  = (in_rd1 == in_rd2);
  assign br_lt  = ($signed(in_rd1) < $signed(in_rd2));
  assign br_ltu = (in_rd1 < in_rd2);

  logic [3:0]        alu_op_next;
  logic              we_next, word_next, mem_rd_next, mem_wr_next;
  logic              taken_next, illegal_next, use_imm, is_jalr;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_next, alu_b_next, tgt_sum, target_next;

  // Combinational instruction decode
  always_comb begin
    alu_op_next  = ALU_ADD;
    we_next      = 1'b0;
    word_next    = 1'b0;
    mem_rd_next  = 1'b0;
    mem_wr_next  = 1'b0;
    taken_next   = 1'b0;
    illegal_next = 1'b0;
    use_imm      = 1'b1;
    is_jalr      = 1'b0;
    imm32        = {{20{in_instr[31]}}, in_instr[31:20]};
    case (opcode)
      OPC_OP: begin
        we_next = 1'b1;
        use_imm = 1'b0;
        case ({funct7, funct3})
          10'b0000000_000: alu_op_next = ALU_ADD;
          10'b0000000_001: alu_op_next = ALU_SLL;
          10'b0000000_010: alu_op_next = ALU_SLT;
          10'b0000000_011: alu_op_next = ALU_SLTU;
          10'b0000000_100: alu_op_next = ALU_XOR;
          10'b0000000_101: alu_op_next = ALU_SRL;
          10'b0000000_110: alu_op_next = ALU_OR;
          10'b0000000_111: alu_op_next = ALU_AND;
          10'b0100000_000: alu_op_next = ALU_SUB;
          10'b0100000_101: alu_op_next = ALU_SRA;
          default:         illegal_next = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        we_next = 1'b1;
        case (funct3)
          3'b000: alu_op_next = ALU_ADD;
          3'b010: alu_op_next = ALU_SLT;
          3'b011: alu_op_next = ALU_SLTU;
          3'b100: alu_op_next = ALU_XOR;
          3'b110: alu_op_next = ALU_OR;
          3'b111: alu_op_next = ALU_AND;
          3'b001: begin
            alu_op_next  = ALU_SLL;
            illegal_next = !sh_lo_ok;
          end
          default: begin
            if (sh_lo_ok)      alu_op_next  = ALU_SRL;
            else if (sh_ra_ok) alu_op_next  = ALU_SRA;
            else               illegal_next = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        we_next     = 1'b1;
        mem_rd_next = 1'b1;
        // LD/LWU only on RV64; 111 never encodes a load
        if (funct3 == 3'b111 || ((funct3 == 3'b011 || funct3 == 3'b110) && XLEN != 64))
          illegal_next = 1'b1;
      end
      OPC_STORE: begin
        imm32       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        mem_wr_next = 1'b1;
        if (funct3[2] || (funct3 == 3'b011 && XLEN != 64))
          illegal_next = 1'b1;
      end
      OPC_BRANCH: begin
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
        use_imm = 1'b0;
        case (funct3)
          3'b000:  taken_next = br_eq;
          3'b001:  taken_next = !br_eq;
          3'b100:  taken_next = br_lt;
          3'b101:  taken_next = !br_lt;
          3'b110:  taken_next = br_ltu;
          3'b111:  taken_next = !br_ltu;
          default: illegal_next = 1'b1;
        endcase
      end
      OPC_JAL: begin
        imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
        we_next    = 1'b1;
        taken_next = 1'b1;
      end
      OPC_JALR: begin
        we_next      = 1'b1;
        taken_next   = 1'b1;
        is_jalr      = 1'b1;
        illegal_next = (funct3 != 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32   = {in_instr[31:12], 12'b0};
        we_next = 1'b1;
      end
      OPC_OP_32: begin
        we_next   = 1'b1;
        word_next = 1'b1;
        use_imm   = 1'b0;
        case ({funct7, funct3})
          10'b0000000_000: alu_op_next = ALU_ADD;
          10'b0100000_000: alu_op_next = ALU_SUB;
          10'b0000000_001: alu_op_next = ALU_SLL;
          10'b0000000_101: alu_op_next = ALU_SRL;
          10'b0100000_101: alu_op_next = ALU_SRA;
          default:         illegal_next = 1'b1;
        endcase
        if (!W_ON) illegal_next = 1'b1;
      end
      OPC_OP_IMM_32: begin
        we_next   = 1'b1;
        word_next = 1'b1;
        case (funct3)
          3'b000: alu_op_next = ALU_ADD;
          3'b001: begin
            alu_op_next  = ALU_SLL;
            illegal_next = (funct7 != 7'b0000000);
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      alu_op_next  = ALU_SRL;
            else if (funct7 == 7'b0100000) alu_op_next  = ALU_SRA;
            else                           illegal_next = 1'b1;
          end
          default: illegal_next = 1'b1;
        endcase
        if (!W_ON) illegal_next = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
    // An undecodable word must have no architectural side effects
    if (illegal_next) begin
      alu_op_next = ALU_NOP;
      we_next     = 1'b0;
      word_next   = 1'b0;
      mem_rd_next = 1'b0;
      mem_wr_next = 1'b0;
      taken_next  = 1'b0;
    end
  end

  // Immediate widening, ALU B select and redirect target
  always_comb begin
    imm_next    = XLEN'(imm32);
    alu_b_next  = use_imm ? imm_next : in_rd2;
    tgt_sum     = (is_jalr ? in_rd1 : in_pc) + imm_next;
    target_next = is_jalr ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;
  end

  assign in_ready = !out_valid || out_ready || flush;

  // Output register: reset, flush, load on accept, drain on consume
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_alu_op        <= 4'b0000;
      out_rs1           <= 5'd0;
      out_rs2           <= 5'd0;
      out_rd            <= 5'd0;
      out_we            <= 1'b0;
      out_imm           <= '0;
      out_alu_b         <= '0;
      out_word          <= 1'b0;
      out_mem_rd        <= 1'b0;
      out_mem_wr        <= 1'b0;
      out_funct3        <= 3'b000;
      out_branch_taken  <= 1'b0;
      out_branch_target <= '0;
      out_illegal       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid         <= 1'b1;
      out_alu_op        <= alu_op_next;
      out_rs1           <= in_instr[19:15];
      out_rs2           <= in_instr[24:20];
      out_rd            <= in_instr[11:7];
      out_we            <= we_next;
      out_imm           <= imm_next;
      out_alu_b         <= alu_b_next;
      out_word          <= word_next;
      out_mem_rd        <= mem_rd_next;
      out_mem_wr        <= mem_wr_next;
      out_funct3        <= funct3;
      out_branch_taken  <= taken_next;
      out_branch_target <= target_next;
      out_illegal       <= illegal_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 ENABLE_W, default 1, enables OP-32/OP-IMM-32 (W) decode; ignored when XLEN=32.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  stage accepts beat this cycle.
REQ-007 in_instr  input  32  instruction word.
REQ-008 in_pc  input  XLEN  instruction address.
REQ-009 in_rd1 / in_rd2  input  XLEN each  rs1/rs2 register values.
REQ-010 flush  input  1  kill held and incoming beats.
REQ-011 out_valid  output  1  decoded beat present.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 out_alu_op  output  4  ALU opcode.
REQ-014 out_rs1 / out_rs2 / out_rd  output  5 each  register addresses.
REQ-015 out_we  output  1  register write enable.
REQ-016 out_imm / out_alu_b  output  XLEN each  immediate; ALU B operand (imm or rd2).
REQ-017 out_word  output  1  W op: ALU result sign-extended from bit 31.
REQ-018 out_mem_rd / out_mem_wr / out_funct3  output  1/1/3  load, store, access size.
REQ-019 out_branch_taken / out_branch_target  output  1/XLEN  redirect and target.
REQ-020 out_illegal  output  1  undecodable instruction.

Function
REQ-021 Single registered stage: all out_* registered; latency one cycle from accepted beat to out_valid.
REQ-022 in_ready SHALL equal (!out_valid || out_ready || flush); beat accepted when in_valid && in_ready.
REQ-023 Accept without flush: load decoded fields, out_valid=1; out_valid && out_ready with no accept: out_valid=0.
REQ-024 While out_valid && !out_ready && !flush, every out_* SHALL hold stable.
REQ-025 Flush: out_valid=0 next cycle; same-cycle incoming beat consumed and discarded; flush beats simultaneous accept.
REQ-026 Opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC; OP-32 (0111011), OP-IMM-32 (0011011) only when XLEN=64 and ENABLE_W=1.
REQ-027 alu_op: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0101, NOP 1010, SLT 1011, SLTU 1100, SLL 1101, SRL 1110, SRA 1111; non-ALU opcodes use ADD.
REQ-028 Immediates sign-extended to XLEN per I/S/B/U/J formats; B and J bit 0 forced 0.
REQ-029 Shift-immediate: XLEN=64 uses 6-bit shamt, instr[31:26] in {000000,010000}; XLEN=32 and W forms require instr[25]=0, else illegal.
REQ-030 W ops: ADDW/SUBW/SLLW/SRLW/SRAW/ADDIW/SLLIW/SRLIW/SRAIW; out_word=1, out_we=1.
REQ-031 Branch compare (BEQ/BNE/BLT/BGE/BLTU/BGEU) on full XLEN rd1/rd2; funct3 010/011 illegal; JAL/JALR taken=1.
REQ-032 Target = (rd1+imm)&~1 for JALR, else pc+imm, modulo 2^XLEN.
REQ-033 Illegal (unknown opcode, bad funct7/funct3, disabled W, JALR funct3!=0): out_illegal=1, out_we=0, mem_rd=mem_wr=0, taken=0, alu_op=1010.
REQ-034 out_we=0 for STORE and BRANCH; out_mem_rd=1 for LOAD, out_mem_wr=1 for STORE.

Reset
REQ-035 rst_n=0 at edge: out_valid=0 and all other out_* =0 (alu_op=0000); incoming beat discarded; dominates flush and handshake; in_ready=1 first cycle after reset.

Verification
REQ-036 0xFFF00093 (ADDI x1,x0,-1) accepted -> next cycle out_valid=1, rd=1, we=1, alu_op=0000, imm=alu_b=all ones.
REQ-037 0x00208463 (BEQ x1,x2,8), pc=0x100, rd1=rd2=5 -> taken=1, target=0x108; rd2=6 -> taken=0.
REQ-038 out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next beat loaded following cycle.
REQ-039 0x003100BB (ADDW x1,x2,x3): XLEN=64 -> out_word=1, alu_op=0000; XLEN=32 or ENABLE_W=0 -> out_illegal=1, we=0.
REQ-040 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle; rst_n=0 mid-stall -> all outputs 0 next cycle.
REQ-041 0xFFFFFFFF -> out_illegal=1, we=0, alu_op=1010, taken=0.
